// File: rtl/sim_video_tap_if.sv
// Pixel stream bundle: coordinates, data enable and per-channel colour.
// The tap takes a COLRW-wide stream in and drives an 8-bit-per-channel stream out.
interface sim_video_tap_if #(
    parameter int unsigned CORDW = 11,
    parameter int unsigned COLW  = 8
);
    logic [CORDW-1:0] sx;
    logic [CORDW-1:0] sy;
    logic             de;
    logic [COLW-1:0]  r;
    logic [COLW-1:0]  g;
    logic [COLW-1:0]  b;

    modport master (output sx, sy, de, r, g, b);
    modport slave  (input  sx, sy, de, r, g, b);
endinterface

// File: rtl/sim_video_tap.sv
// Pixel-stream output stage feeding the SDL harness: DELAY-deep pipeline, colour
// expansion to 8 bits, blanking, frame-start/frame-count tracking and error flags.
// Optional per-frame CRC-32 signature is built when SIM_VIDEO_TAP_CRC_EN is defined.
module sim_video_tap #(
    parameter int unsigned CORDW = 11,
    parameter int unsigned COLRW = 4,
    parameter int unsigned DELAY = 1,
    parameter int unsigned H_RES = 640,
    parameter int unsigned V_RES = 480
) (
    input  logic                  clk_pix,
    input  logic                  rst_pix,
    sim_video_tap_if.slave        pix,
    sim_video_tap_if.master       sdl,
    output logic                  frame_start,
    output logic [15:0]           frame_count,
    output logic                  frame_err,
    output logic                  coord_err,
    output logic [31:0]           signature,
    output logic                  sig_valid
);
    localparam logic [31:0] FramePix = 32'(H_RES * V_RES);

    typedef struct packed {
        logic             de;
        logic [CORDW-1:0] sx;
        logic [CORDW-1:0] sy;
        logic [7:0]       r;
        logic [7:0]       g;
        logic [7:0]       b;
    } px_t;

    // Replicate the input bits MSB-first until 8 bits are filled.
    function automatic logic [7:0] expand(input logic [COLRW-1:0] c);
        logic [7:0] e;
        e = '0;
        for (int i = 0; i < 8; i++) begin
            e[7-i] = c[COLRW-1-(i % COLRW)];
        end
        return e;
    endfunction

    px_t in_px;
    px_t pre_px;   // sample one stage before the output register
    px_t out_px;
    px_t stage_q [DELAY];
    logic pre_fs;
    logic seen_q;
    logic [31:0] pix_cnt_q;

    // Expand and blank at the input so every stage carries final 8-bit colour.
    always_comb begin
        in_px    = '0;
        in_px.de = pix.de;
        in_px.sx = pix.sx;
        in_px.sy = pix.sy;
        in_px.r  = pix.de ? expand(pix.r) : 8'h00;
        in_px.g  = pix.de ? expand(pix.g) : 8'h00;
        in_px.b  = pix.de ? expand(pix.b) : 8'h00;
    end

    // Delay line: stage 0 samples the inputs, the last stage drives the outputs.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            for (int i = 0; i < DELAY; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= in_px;
            for (int i = 1; i < DELAY; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    // Frame-start is decoded one stage early so it registers alongside pixel (0,0).
    generate
        if (DELAY == 1) begin : g_pre_in
            assign pre_px = in_px;
        end else begin : g_pre_stage
            assign pre_px = stage_q[DELAY-2];
        end
    endgenerate

    assign out_px = stage_q[DELAY-1];
    assign pre_fs = pre_px.de && (pre_px.sx == '0) && (pre_px.sy == '0);

    assign sdl.de = out_px.de;
    assign sdl.sx = out_px.sx;
    assign sdl.sy = out_px.sy;
    assign sdl.r  = out_px.r;
    assign sdl.g  = out_px.g;
    assign sdl.b  = out_px.b;

    // Frame-start flag and frame counter, aligned with the (0,0) output cycle.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            frame_start <= 1'b0;
            frame_count <= 16'h0000;
        end else begin
            frame_start <= pre_fs;
            if (pre_fs) frame_count <= frame_count + 16'd1;
        end
    end

    // Pixel count per frame; the first frame after reset is never checked.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            seen_q    <= 1'b0;
            pix_cnt_q <= 32'd0;
            frame_err <= 1'b0;
        end else if (frame_start) begin
            if (seen_q && (pix_cnt_q != FramePix)) frame_err <= 1'b1;
            pix_cnt_q <= 32'd1;
            seen_q    <= 1'b1;
        end else if (out_px.de) begin
            pix_cnt_q <= pix_cnt_q + 32'd1;
        end
    end

    // Out-of-range coordinate with de=1, caught as the input is sampled; sticky.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            coord_err <= 1'b0;
        end else if (pix.de && ((32'(pix.sx) >= H_RES) || (32'(pix.sy) >= V_RES))) begin
            coord_err <= 1'b1;
        end
    end

`ifdef SIM_VIDEO_TAP_CRC_EN
    localparam logic [31:0] CrcPoly = 32'h04C1_1DB7;
    localparam logic [31:0] CrcInit = 32'hFFFF_FFFF;

    // CRC-32, MSB-first, folding 24 bits {r,g,b}.
    function automatic logic [31:0] crc_px(input logic [31:0] c, input logic [23:0] d);
        logic [31:0] x;
        x = c;
        for (int i = 23; i >= 0; i--) begin
            if (x[31] ^ d[i]) x = {x[30:0], 1'b0} ^ CrcPoly;
            else              x = {x[30:0], 1'b0};
        end
        return x;
    endfunction

    logic [31:0] crc_q;

    // Publish the finished frame's CRC on each frame start, then restart with (0,0).
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            crc_q     <= CrcInit;
            signature <= 32'h0;
            sig_valid <= 1'b0;
        end else if (frame_start) begin
            if (seen_q) begin
                signature <= crc_q;
                sig_valid <= 1'b1;
            end else begin
                sig_valid <= 1'b0;
            end
            crc_q <= crc_px(CrcInit, {out_px.r, out_px.g, out_px.b});
        end else begin
            sig_valid <= 1'b0;
            if (out_px.de) crc_q <= crc_px(crc_q, {out_px.r, out_px.g, out_px.b});
        end
    end
`else
    assign signature = 32'h0;
    assign sig_valid = 1'b0;
`endif

endmodule

// File: tb/tb_sim_video_tap.sv
// Bench for sim_video_tap (DELAY=3, COLRW=4, 4x2 frames): table vectors and frame
// sequences driven through a scoreboard that models the tap at its output.
module tb_sim_video_tap;
    localparam int unsigned DLY = 3;
    localparam int unsigned HR  = 4;
    localparam int unsigned VR  = 2;

    logic clk_pix = 1'b0;
    logic rst_pix = 1'b1;
    logic        frame_start, frame_err, coord_err, sig_valid;
    logic [15:0] frame_count;
    logic [31:0] signature;

    sim_video_tap_if #(.CORDW(11), .COLW(4)) pin ();
    sim_video_tap_if #(.CORDW(11), .COLW(8)) pout ();

    sim_video_tap #(.CORDW(11), .COLRW(4), .DELAY(DLY), .H_RES(HR), .V_RES(VR)) dut (
        .clk_pix     (clk_pix),
        .rst_pix     (rst_pix),
        .pix         (pin),
        .sdl         (pout),
        .frame_start (frame_start),
        .frame_count (frame_count),
        .frame_err   (frame_err),
        .coord_err   (coord_err),
        .signature   (signature),
        .sig_valid   (sig_valid)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct {
        logic de; logic [10:0] sx; logic [10:0] sy;
        logic [7:0] r; logic [7:0] g; logic [7:0] b; logic fs;
    } exp_t;

    typedef struct {
        logic de; int sx; int sy; logic [3:0] r; logic [3:0] g; logic [3:0] b;
        logic [7:0] er; logic [7:0] eg; logic [7:0] eb;
    } vec_t;

    exp_t        sb [$];
    logic [31:0] dut_sigs [$];
    int n_vec = 0;
    int n_err = 0;
    int fs_seen = 0;

    // Output-side model state.
    logic [15:0] m_fc;
    bit          m_ferr, m_cerr, m_seen, m_sv;
    int          m_pix;
    logic [31:0] m_acc, m_sig;

    function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [23:0] d);
        logic [31:0] x;
        logic bt;
        x = c;
        for (int i = 0; i < 24; i++) begin
            bt = d[23-i];
            x = (x[31] ^ bt) ? ((x << 1) ^ 32'h04C11DB7) : (x << 1);
        end
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        exp_t z;
        z = '{de: 1'b0, sx: 11'd0, sy: 11'd0, r: 8'd0, g: 8'd0, b: 8'd0, fs: 1'b0};
        sb.delete();
        for (int i = 0; i < DLY - 1; i++) sb.push_back(z);
        m_fc = 16'd0; m_ferr = 0; m_cerr = 0; m_seen = 0; m_sv = 0;
        m_pix = 0; m_acc = 32'hFFFFFFFF; m_sig = 32'd0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_de"}, 32'(pout.de), 32'd0);
        check({tag, "_rgb"}, {8'd0, pout.r, pout.g, pout.b}, 32'd0);
        check({tag, "_xy"}, {5'd0, pout.sx, 5'd0, pout.sy}, 32'd0);
        check({tag, "_fs"}, 32'(frame_start), 32'd0);
        check({tag, "_fc"}, 32'(frame_count), 32'd0);
        check({tag, "_flags"}, {30'd0, frame_err, coord_err}, 32'd0);
        check({tag, "_sig"}, signature, 32'd0);
        check({tag, "_sv"}, 32'(sig_valid), 32'd0);
    endtask

    task automatic compare_out(input exp_t o);
        check("sdl_de", 32'(pout.de), 32'(o.de));
        check("sdl_xy", {5'd0, pout.sx, 5'd0, pout.sy}, {5'd0, o.sx, 5'd0, o.sy});
        check("sdl_rgb", {8'd0, pout.r, pout.g, pout.b}, {8'd0, o.r, o.g, o.b});
        check("frame_start", 32'(frame_start), 32'(o.fs));
        if (o.fs) m_fc = m_fc + 16'd1;
        check("frame_count", 32'(frame_count), 32'(m_fc));
        check("frame_err", 32'(frame_err), 32'(m_ferr));
        check("sig_valid", 32'(sig_valid), 32'(m_sv));
        check("signature", signature, m_sig);
        if (frame_start) fs_seen++;
        if (sig_valid) dut_sigs.push_back(signature);
        // Advance the model to what the next output cycle should show.
        if (o.fs) begin
            if (m_seen && m_pix != int'(HR * VR)) m_ferr = 1;
`ifdef SIM_VIDEO_TAP_CRC_EN
            m_sv = m_seen;
            if (m_seen) m_sig = m_acc;
            m_acc = crc_model(32'hFFFFFFFF, {o.r, o.g, o.b});
`endif
            m_pix  = 1;
            m_seen = 1;
        end else begin
            m_sv = 0;
            if (o.de) begin
                m_pix++;
                m_acc = crc_model(m_acc, {o.r, o.g, o.b});
            end
        end
    endtask

    task automatic step_x(input logic de, input int sx, input int sy,
                          input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                          input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
        exp_t e;
        exp_t o;
        pin.de = de; pin.sx = 11'(sx); pin.sy = 11'(sy);
        pin.r = r; pin.g = g; pin.b = b;
        @(posedge clk_pix); #1;
        e = '{de: de, sx: 11'(sx), sy: 11'(sy), r: er, g: eg, b: eb,
              fs: de && sx == 0 && sy == 0};
        if (de && (sx >= int'(HR) || sy >= int'(VR))) m_cerr = 1;
        check("coord_err", 32'(coord_err), 32'(m_cerr));
        sb.push_back(e);
        if (sb.size() == DLY) begin
            o = sb.pop_front();
            compare_out(o);
        end
    endtask

    task automatic step(input logic de, input int sx, input int sy,
                        input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        if (de) step_x(de, sx, sy, r, g, b, {r, r}, {g, g}, {b, b});
        else    step_x(de, sx, sy, r, g, b, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 4'h0, 4'h0, 4'h0);
    endtask

    // One 4x2 frame with a blank gap after each line; (kx,ky) dropped or altered.
    task automatic send_frame(input logic [3:0] salt, input int kx, input int ky,
                              input bit alter);
        for (int y = 0; y < int'(VR); y++) begin
            for (int x = 0; x < int'(HR); x++) begin
                logic [3:0] rr;
                rr = 4'(x) + salt;
                if (x == kx && y == ky && alter) rr = rr ^ 4'h8;
                if (x == kx && y == ky && !alter)
                    step(1'b0, x, y, rr, 4'(y * 3) + salt, salt ^ 4'(x));
                else
                    step(1'b1, x, y, rr, 4'(y * 3) + salt, salt ^ 4'(x));
            end
            idle(1);
        end
    endtask

    // Asynchronous reset between clock edges; outputs must clear immediately.
    task automatic async_reset(input string tag);
        #2 rst_pix = 1'b1;
        #1 check_all_zero(tag);
        @(posedge clk_pix); #1;
        pin.de = 1'b0;
        rst_pix = 1'b0;
        reset_model();
    endtask

    vec_t tbl [6];

    initial begin
        tbl[0] = '{1'b1, 1, 1, 4'hA, 4'h5, 4'hF, 8'hAA, 8'h55, 8'hFF};
        tbl[1] = '{1'b0, 2, 1, 4'hA, 4'h5, 4'hF, 8'h00, 8'h00, 8'h00};
        tbl[2] = '{1'b1, 3, 1, 4'h3, 4'hC, 4'h0, 8'h33, 8'hCC, 8'h00};
        tbl[3] = '{1'b1, 2, 0, 4'h1, 4'h8, 4'h7, 8'h11, 8'h88, 8'h77};
        tbl[4] = '{1'b0, 1, 0, 4'hF, 4'hF, 4'hF, 8'h00, 8'h00, 8'h00};
        tbl[5] = '{1'b1, 1, 0, 4'h6, 4'h9, 4'hE, 8'h66, 8'h99, 8'hEE};

        pin.de = 1'b0; pin.sx = '0; pin.sy = '0; pin.r = '0; pin.g = '0; pin.b = '0;
        repeat (2) @(posedge clk_pix);
        #1 check_all_zero("reset");
        rst_pix = 1'b0;
        reset_model();

        // Expansion, blanking and latency through the scoreboard.
        for (int i = 0; i < 6; i++)
            step_x(tbl[i].de, tbl[i].sx, tbl[i].sy, tbl[i].r, tbl[i].g, tbl[i].b,
                   tbl[i].er, tbl[i].eg, tbl[i].eb);
        idle(DLY);

        // Three complete frames.
        async_reset("rst_a");
        fs_seen = 0;
        for (int f = 0; f < 3; f++) send_frame(4'(f + 2), -1, -1, 1'b0);
        idle(DLY);
        check("fs_pulses", 32'(fs_seen), 32'd3);
        check("fc_after3", 32'(frame_count), 32'd3);
        check("ferr_after3", 32'(frame_err), 32'd0);

        // Short second frame: error after the third frame start, then sticky.
        async_reset("rst_b");
        send_frame(4'h1, -1, -1, 1'b0);
        send_frame(4'h1, 2, 1, 1'b0);
        send_frame(4'h1, -1, -1, 1'b0);
        idle(DLY + 2);
        check("ferr_sticky", 32'(frame_err), 32'd1);

        // Coordinate error, sticky, then a mid-frame reset clears everything.
        step(1'b1, 4, 0, 4'h2, 4'h2, 4'h2);
        idle(3);
        check("cerr_sticky", 32'(coord_err), 32'd1);
        step(1'b1, 0, 0, 4'h3, 4'h3, 4'h3);
        step(1'b1, 1, 0, 4'h3, 4'h3, 4'h3);
        async_reset("rst_mid");
        send_frame(4'h7, -1, -1, 1'b0);
        send_frame(4'h7, -1, -1, 1'b0);
        idle(DLY);
        check("ferr_after_rst", 32'(frame_err), 32'd0);

        // Back-to-back (0,0) samples: two frame starts, the second sees one pixel.
        async_reset("rst_c");
        step(1'b1, 0, 0, 4'h4, 4'h4, 4'h4);
        step(1'b1, 0, 0, 4'h4, 4'h4, 4'h4);
        idle(DLY + 1);
        check("b2b_fc", 32'(frame_count), 32'd2);
        check("b2b_ferr", 32'(frame_err), 32'd1);

`ifdef SIM_VIDEO_TAP_CRC_EN
        // Two identical frames then one altered pixel; a fourth frame closes the third.
        async_reset("rst_crc");
        dut_sigs.delete();
        send_frame(4'h5, -1, -1, 1'b0);
        send_frame(4'h5, -1, -1, 1'b0);
        send_frame(4'h5, 1, 1, 1'b1);
        send_frame(4'h5, -1, -1, 1'b0);
        idle(DLY);
        check("sig_count", 32'(dut_sigs.size()), 32'd3);
        if (dut_sigs.size() == 3) begin
            check("sig_equal", dut_sigs[1], dut_sigs[0]);
            n_vec++;
            if (dut_sigs[2] === dut_sigs[1]) begin
                n_err++;
                $display("FAIL sig_differs: got %0h want value other than %0h",
                         dut_sigs[2], dut_sigs[1]);
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sim_video_tap.md
# sim_video_tap

Parametrised pixel-stream output stage between the display pipeline (`main`) and the Verilator SDL harness. It delays sync, coordinate and colour signals through a configurable pipeline and expands COLRW-bit colour to 8 bits per channel. It blanks colour outside the active area and tracks frame structure: frame-start pulse, frame counter and pixel-count error flag. An optional per-frame CRC signature lets benches check rendered frames without dumping images.

## Interface
Parameters:
- `CORDW`, 11, coordinate width
- `COLRW`, 4, input colour bits per channel (1..8)
- `DELAY`, 1, pipeline stages from input to output (1..8)
- `H_RES`, 640, active pixels per line
- `V_RES`, 480, active lines per frame

Ports:
- `clk_pix` in 1 pixel clock; sole clock
- `rst_pix` in 1 reset, asynchronous, active-high
- `sx`, `sy` in CORDW input coordinates
- `de` in 1 input data enable
- `r`, `g`, `b` in COLRW input colour
- `sdl_sx`, `sdl_sy` out CORDW delayed coordinates
- `sdl_de` out 1 delayed data enable
- `sdl_r`, `sdl_g`, `sdl_b` out 8 expanded colour
- `frame_start` out 1 high while outputs carry pixel (0,0) with `sdl_de`=1
- `frame_count` out 16 completed-frame-start count
- `frame_err` out 1 sticky: a completed frame had ≠ H_RES*V_RES enabled pixels
- `coord_err` out 1 sticky: `de`=1 with `sx`≥H_RES or `sy`≥V_RES
- `signature` out 32 CRC of previous frame (CRC build only)
- `sig_valid` out 1 one-cycle strobe when `signature` updates (CRC build only)

## Operation
- Pipeline: DELAY register stages; every output is a registered value with no combinational path from inputs.
- Colour expansion: replicate input bits MSB-first and keep the top 8 bits.
  - COLRW=4: 0xA → 0xAA.
  - COLRW=5: 0b10110 → 0b10110101.
  - COLRW=1: 1 → 0xFF.
  - COLRW=8: pass-through.
- Blanking: when the delayed `de`=0, `sdl_r/g/b` = 0. Coordinates still pass through.
- Frame start: asserted when the delayed sample has de=1, sx=0 and sy=0.
- Frame counter: `frame_count` increments on each `frame_start` and wraps 0xFFFF → 0x0000.
- Pixel counter (32-bit): counts delayed de=1 cycles.
  - On `frame_start`, if at least one previous `frame_start` has occurred since reset and the count ≠ H_RES*V_RES, set `frame_err`.
  - The counter then reloads to 1, counting pixel (0,0).
  - Pixels before the first `frame_start` are counted but never checked.
- `coord_err`: evaluated on the input sample register (stage 1); set one cycle after the offending input. Sticky until reset.
- Simultaneous conditions: `frame_err` and `coord_err` may set in the same cycle; each is independent.

## Timing
- Latency: an input sampled at edge N appears on `sdl_*` after edge N+DELAY-1. DELAY=1 equals a single output register.
- `frame_start` and `frame_count` increment align with the same output cycle as pixel (0,0).
- `frame_err` is set on the cycle after `frame_start`.
- Reset values: all outputs 0, `signature` 0, pipeline contents 0.
  - Pipeline de=0, so no spurious `frame_start` appears after reset.
- Reset mid-frame: all state clears immediately. The next `frame_start` is treated as the first, so there is no error check.
- Back-to-back frame starts (the (0,0) pixel repeated on consecutive cycles): each one is a frame start. The count check sees 1 pixel and sets `frame_err` unless H_RES*V_RES=1.

## Configuration
- `SIM_VIDEO_TAP_CRC_EN` defined: CRC-32 accumulator is built in.
  - Polynomial 0x04C11DB7, MSB-first, no reflection, init 0xFFFFFFFF, no final XOR.
  - Processes 24 bits {sdl_r,sdl_g,sdl_b} per delayed de=1 cycle.
  - On `frame_start`, if not the first frame since reset, `signature` ← accumulator and `sig_valid` pulses one cycle after `frame_start`.
  - The accumulator then restarts from init, folding in pixel (0,0).
- Macro undefined: no CRC logic; `signature` is tied to 0 and `sig_valid` to 0. Ports remain present.

## Test plan
- Reset: assert `rst_pix` asynchronously mid-stream → all outputs 0 in the same cycle; `frame_count`=0; flags clear.
- Latency and expansion: DELAY=3, COLRW=4, drive r/g/b=0xA/0x5/0xF with de=1 → `sdl_r/g/b`=0xAA/0x55/0xFF exactly 3 edges later; with de=0 → 0/0/0.
- Frame tracking: H_RES=4, V_RES=2, three full 8-pixel frames → three `frame_start` pulses, `frame_count`=3, `frame_err`=0.
- Short frame: H_RES=4, V_RES=2, second frame has 7 enabled pixels → `frame_err`=1 on the cycle after the third `frame_start`; stays 1.
- Coordinate error: de=1 with sx=4 (H_RES=4) → `coord_err`=1 one cycle later, sticky until reset.
- CRC (macro defined): two identical frames → two `sig_valid` strobes with equal `signature`, matching the bench model. Changing one pixel in the next frame → a different `signature`.
